div_pipe: RTL and testbench

DIV_PIPE -- requirements
Module: div_pipe

---
 rtl/tproc_div_pkg.sv | 19 +
 rtl/div_pipe_stage.sv | 38 +++
 rtl/div_pipe.sv | 171 +++++++++++++++++
 tb/tb_div_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tproc_div_pkg.sv
// Shared types and helpers for the pipelined divider.
package tproc_div_pkg;

  // Per-operation flags carried alongside the partial remainder/quotient.
  // The full stage record adds tag and datapath fields whose widths depend
  // on the instantiating module's parameters.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic div0;
    logic ovf;
  } div_flags_t;

  // Cycles from the sampling edge to the result edge.
  function automatic int div_latency(input int n_pipe);
    return n_pipe + 1;
  endfunction

endpackage

// File: rtl/div_pipe_stage.sv
// One slice of the restoring divider: STEPS quotient bits, MSB first.
module div_pipe_stage #(
  parameter int DW      = 32,
  parameter int STEPS   = 8,
  parameter int BIT_OFS = 0
) (
  input  logic [DW-1:0] rem_i,
  input  logic [DW-1:0] quo_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic [DW-1:0] quo_o
);

  logic [DW:0] rem_sh;
  logic [DW:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  // quo carries unconsumed dividend bits; each consumed bit is replaced
  // in place by its quotient bit. Since rem < divisor, diff[DW] is the borrow.
  always_comb begin
    rem_o  = rem_i;
    quo_o  = quo_i;
    rem_sh = '0;
    diff   = '0;
    for (int s = 0; s < STEPS; s++) begin
      rem_sh = {rem_o, quo_o[DW-1-BIT_OFS-s]};
      diff   = rem_sh - {1'b0, dvs_i};
      if (diff[DW]) begin
        rem_o                 = rem_sh[DW-1:0];
        quo_o[DW-1-BIT_OFS-s] = 1'b0;
      end else begin
        rem_o                 = diff[DW-1:0];
        quo_o[DW-1-BIT_OFS-s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_pipe.sv
// Fully pipelined restoring divider with tags, flush and special-case flags.
module div_pipe
  import tproc_div_pkg::*;
#(
  parameter int DW     = 32,
  parameter int N_PIPE = 4,
  parameter int TW     = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [DW-1:0] A_i,
  input  logic [DW-1:0] B_i,
  input  logic [TW-1:0] tag_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          valid_o,
  output logic [DW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o,
  output logic [TW-1:0] tag_o,
  output logic          div0_o,
  output logic          ovf_o
);

  localparam int STEPS = DW / N_PIPE;
  // Input register plus one register behind every division stage.
  localparam int NREC = div_latency(N_PIPE);
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  if ((DW % N_PIPE) != 0) begin : g_cfg_check
    $error("div_pipe: DW must be a multiple of N_PIPE");
  end

  typedef struct packed {
    div_flags_t    flags;
    logic [TW-1:0] tag;
    logic [DW-1:0] rem;
    logic [DW-1:0] quo;
    logic [DW-1:0] dvs;
  } stage_rec_t;

  logic [NREC-1:0] vld_d, vld_q;
  stage_rec_t      rec_d [NREC];
  stage_rec_t      rec_q [NREC];
  logic [DW-1:0]   stage_rem [N_PIPE];
  logic [DW-1:0]   stage_quo [N_PIPE];

  logic            a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW-1:0]   q_fix, r_fix;

  logic            ready_d, ready_q;
  logic            valid_d, valid_q;
  logic            div0_d, div0_q;
  logic            ovf_d, ovf_q;
  logic [DW-1:0]   quotient_d, quotient_q;
  logic [DW-1:0]   remainder_d, remainder_q;
  logic [TW-1:0]   tag_d, tag_q;

  // Operand magnitudes and sign information for the input register.
  always_comb begin
    a_neg = signed_i & A_i[DW-1];
    b_neg = signed_i & B_i[DW-1];
    a_mag = a_neg ? -A_i : A_i;
    b_mag = b_neg ? -B_i : B_i;
  end

  for (genvar j = 0; j < N_PIPE; j++) begin : g_stage
    div_pipe_stage #(
      .DW      (DW),
      .STEPS   (STEPS),
      .BIT_OFS (j * STEPS)
    ) u_stage (
      .rem_i (rec_q[j].rem),
      .quo_i (rec_q[j].quo),
      .dvs_i (rec_q[j].dvs),
      .rem_o (stage_rem[j]),
      .quo_o (stage_quo[j])
    );
  end

  // Next valid chain and stage records; a flush kills everything already in flight.
  always_comb begin
    vld_d[0]             = start_i & ready_q;
    rec_d[0].flags.neg_q = a_neg ^ b_neg;
    rec_d[0].flags.neg_r = a_neg;
    rec_d[0].flags.div0  = (B_i == '0);
    rec_d[0].flags.ovf   = signed_i & (A_i == MIN_NEG) & (B_i == '1);
    rec_d[0].tag         = tag_i;
    rec_d[0].rem         = '0;
    rec_d[0].quo         = a_mag;
    rec_d[0].dvs         = b_mag;
    for (int j = 0; j < N_PIPE; j++) begin
      vld_d[j+1]     = vld_q[j] & ~flush_i;
      rec_d[j+1]     = rec_q[j];
      rec_d[j+1].rem = stage_rem[j];
      rec_d[j+1].quo = stage_quo[j];
    end
  end

  // Valid chain and ready flag are the only pipeline state that needs reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      ready_q <= ready_d;
    end
  end

  // Stage data registers load only when an operation enters them.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NREC; j++) begin
      if (vld_d[j]) begin
        rec_q[j] <= rec_d[j];
      end
    end
  end

  // Sign-correct the final record; results hold and flags drop between strobes.
  always_comb begin
    ready_d     = 1'b1;
    valid_d     = vld_q[N_PIPE] & ~flush_i;
    q_fix       = rec_q[N_PIPE].flags.neg_q ? -rec_q[N_PIPE].quo : rec_q[N_PIPE].quo;
    r_fix       = rec_q[N_PIPE].flags.neg_r ? -rec_q[N_PIPE].rem : rec_q[N_PIPE].rem;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    tag_d       = tag_q;
    div0_d      = 1'b0;
    ovf_d       = 1'b0;
    if (valid_d) begin
      quotient_d  = rec_q[N_PIPE].flags.div0 ? '1 : q_fix;
      remainder_d = r_fix;
      tag_d       = rec_q[N_PIPE].tag;
      div0_d      = rec_q[N_PIPE].flags.div0;
      ovf_d       = rec_q[N_PIPE].flags.ovf;
    end
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      tag_q       <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      tag_q       <= tag_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = (|vld_q) | valid_q;
  assign valid_o     = valid_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign tag_o       = tag_q;
  assign div0_o      = div0_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_div_pipe.sv
// Scoreboard bench for div_pipe: stimulus pushes expected results, a monitor pops them.
module tb_div_pipe;

  localparam int DW     = 32;
  localparam int N_PIPE = 4;
  localparam int TW     = 4;
  localparam int LAT    = N_PIPE + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic [TW-1:0] tag;
    logic          div0;
    logic          ovf;
    int            due;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          signed_i;
  logic [DW-1:0] A_i;
  logic [DW-1:0] B_i;
  logic [TW-1:0] tag_i;
  logic          flush_i;
  logic          ready_o;
  logic          busy_o;
  logic          valid_o;
  logic [DW-1:0] quotient_o;
  logic [DW-1:0] remainder_o;
  logic [TW-1:0] tag_o;
  logic          div0_o;
  logic          ovf_o;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cycle = 0;
  exp_t exp_q[$];
  logic [DW-1:0] last_q   = '0;
  logic [DW-1:0] last_r   = '0;
  logic [TW-1:0] last_tag = '0;

  div_pipe #(.DW(DW), .N_PIPE(N_PIPE), .TW(TW)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .A_i         (A_i),
    .B_i         (B_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .tag_o       (tag_o),
    .div0_o      (div0_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: plain integer arithmetic plus the two special cases.
  function automatic exp_t ref_div(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [TW-1:0] tg);
    exp_t   e;
    longint sa, sb;
    e.tag  = tg;
    e.div0 = 1'b0;
    e.ovf  = 1'b0;
    e.due  = 0;
    if (b == 0) begin
      e.q    = '1;
      e.r    = a;
      e.div0 = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q   = a;
      e.r   = '0;
      e.ovf = 1'b1;
    end else if (sg) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'(-int'($urandom_range(1, 20)));
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock of stimulus; the expected-result queue is updated as the edge applies.
  task automatic drive(input logic st, input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tg, input logic fl, input exp_t e);
    exp_t ent;
    start_i  = st;
    signed_i = sg;
    A_i      = a;
    B_i      = b;
    tag_i    = tg;
    flush_i  = fl;
    @(posedge clk_i);
    #1;
    if (fl) exp_q.delete();
    if (st) begin
      ent     = e;
      ent.due = cycle + LAT;
      exp_q.push_back(ent);
    end
    start_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic apply_stimulus(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [TW-1:0] tg, input logic fl);
    drive(1'b1, sg, a, b, tg, fl, ref_div(sg, a, b, tg));
  endtask

  task automatic apply_directed(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [TW-1:0] tg, input logic [DW-1:0] q, input logic [DW-1:0] r,
                                input logic d0, input logic ov);
    exp_t e;
    e.q    = q;
    e.r    = r;
    e.tag  = tg;
    e.div0 = d0;
    e.ovf  = ov;
    e.due  = 0;
    drive(1'b1, sg, a, b, tg, 1'b0, e);
  endtask

  task automatic idle(input int n, input logic fl = 1'b0);
    exp_t e;
    e = ref_div(1'b0, 32'd1, 32'd1, '0);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, fl, e);
  endtask

  // Monitor: pop and compare on every strobe, check hold behaviour otherwise.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (valid_o) begin
        check_output("busy_while_valid", 32'(busy_o), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("[TB] FAIL unexpected_valid: got valid_o=1 tag=%0d q=0x%08h, expected no result (cycle %0d)",
                   tag_o, quotient_o, cycle);
        end else begin
          e = exp_q.pop_front();
          check_output("latency_cycle", 32'(cycle), 32'(e.due));
          check_output("quotient", quotient_o, e.q);
          check_output("remainder", remainder_o, e.r);
          check_output("tag", 32'(tag_o), 32'(e.tag));
          check_output("div0", 32'(div0_o), 32'(e.div0));
          check_output("ovf", 32'(ovf_o), 32'(e.ovf));
          last_q   = e.q;
          last_r   = e.r;
          last_tag = e.tag;
        end
      end else begin
        check_output("idle_flags", {30'd0, div0_o, ovf_o}, 32'd0);
        check_output("hold_quotient", quotient_o, last_q);
        check_output("hold_remainder", remainder_o, last_r);
        check_output("hold_tag", 32'(tag_o), 32'(last_tag));
      end
      if (exp_q.size() > 0 && exp_q[0].due < cycle) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_mis++;
        $display("[TB] FAIL missing_valid: got no result by cycle %0d, expected tag %0d at cycle %0d",
                 cycle, e.tag, e.due);
      end
    end
  end

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    A_i      = '0;
    B_i      = '0;
    tag_i    = '0;
    flush_i  = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check_output("reset_valid", 32'(valid_o), 32'd0);
    check_output("reset_busy", 32'(busy_o), 32'd0);
    check_output("reset_ready", 32'(ready_o), 32'd0);
    check_output("reset_flags", {30'd0, div0_o, ovf_o}, 32'd0);
    check_output("reset_quotient", quotient_o, '0);
    check_output("reset_remainder", remainder_o, '0);
    check_output("reset_tag", 32'(tag_o), 32'd0);
    rst_ni = 1'b1;
    idle(1);
    check_output("ready_after_release", 32'(ready_o), 32'd1);

    $display("[TB] basic unsigned divide");
    apply_directed(1'b0, 32'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0);
    check_output("busy_after_issue", 32'(busy_o), 32'd1);
    idle(LAT + 3);
    check_output("busy_after_drain", 32'(busy_o), 32'd0);

    $display("[TB] signed and special cases");
    apply_directed(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply_directed(1'b1, 32'd7, 32'hFFFF_FFFE, 4'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    apply_directed(1'b0, 32'd5, 32'd0, 4'd4, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    apply_directed(1'b1, 32'd5, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    apply_directed(1'b1, 32'hFFFF_FFFB, 32'd0, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
    apply_directed(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    apply_directed(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    apply_directed(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    idle(LAT + 3);

    $display("[TB] eight back-to-back operations");
    for (int i = 0; i < 8; i++) apply_stimulus(1'($urandom), rand_op(), rand_op(), 4'(i), 1'b0);
    idle(LAT + 3);

    $display("[TB] flush with concurrent issue");
    apply_stimulus(1'b0, 32'd50, 32'd5, 4'd1, 1'b0);
    apply_stimulus(1'b0, 32'd60, 32'd6, 4'd2, 1'b0);
    apply_stimulus(1'b0, 32'd70, 32'd7, 4'd3, 1'b1);
    idle(LAT + 3);

    $display("[TB] reset with operations in flight");
    apply_stimulus(1'b0, 32'd11, 32'd2, 4'd10, 1'b0);
    apply_stimulus(1'b1, 32'hFFFF_FF00, 32'd3, 4'd11, 1'b0);
    apply_stimulus(1'b0, 32'd13, 32'd4, 4'd12, 1'b0);
    rst_ni = 1'b0;
    exp_q.delete();
    last_q   = '0;
    last_r   = '0;
    last_tag = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_output("busy_after_reset", 32'(busy_o), 32'd0);
    idle(1);
    check_output("ready_after_reset", 32'(ready_o), 32'd1);
    idle(LAT + 3);
    apply_directed(1'b0, 32'd9, 32'd3, 4'd5, 32'd3, 32'd0, 1'b0, 1'b0);
    idle(LAT + 3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        apply_stimulus(1'($urandom), rand_op(), rand_op(), 4'($urandom), ($urandom_range(0, 24) == 0));
      else
        idle(1, ($urandom_range(0, 24) == 0));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    check_output("busy_final", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
